// File: rtl/openram_gpio_pkg.sv
// Shared definitions for the OpenRAM GPIO packet path.
//   state_t          : controller state encoding
//   PACKET_WIDTH_DEF : bits per command packet (chip select + connection word)
//   DATA_WIDTH_DEF   : bits of SRAM read data returned per frame
//   CS_MSB / CS_LSB  : chip-select field inside a packet
//   cnt_width()      : counter width able to count down from the larger width
package openram_gpio_pkg;

   localparam int PACKET_WIDTH_DEF = 86;
   localparam int DATA_WIDTH_DEF   = 64;
   localparam int CS_MSB           = 85;
   localparam int CS_LSB           = 83;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SHIFT_IN  = 3'd1,
      LAUNCH    = 3'd2,
      WAIT_READ = 3'd3,
      SHIFT_OUT = 3'd4
   } state_t;

   function automatic int cnt_width(input int a, input int b);
      return $clog2((a > b) ? a : b);
   endfunction

endpackage

// File: rtl/gpio_shift_reg.sv
// Parallel-load / serial-in shift register, shifts towards the MSB.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : parallel load of load_data (wins over shift_en)
//   load_data   : parallel input word
//   shift_en    : shift left one place, serial_in enters at bit 0
//   serial_in   : serial input bit
//   data_q      : register contents
//   msb_out     : current MSB, i.e. the next bit to leave the register
module gpio_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift_en,
   input  logic             serial_in,
   output logic [WIDTH-1:0] data_q,
   output logic             msb_out
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         data_q <= '0;
      else if (load)
         data_q <= load_data;
      else if (shift_en)
         data_q <= {data_q[WIDTH-2:0], serial_in};
   end

   assign msb_out = data_q[WIDTH-1];

endmodule

// File: rtl/gpio_packet_shifter.sv
// GPIO serial front/back end for the SRAM test controller.
// Deserialises a command packet (MSB first) framed by a rising edge of
// gpio_load, presents it with a one-cycle packet_valid, waits READ_WAIT
// cycles, samples read_data and serialises it back out MSB first.
//   gpio_clock, reset_n : clock, asynchronous active-low reset
//   gpio_in, gpio_load  : serial command bit, frame enable
//   read_data           : parallel read word from the test controller
//   packet_out          : last complete packet, packet_valid pulses on update
//   read_capture        : pulses on the cycle read_data is sampled
//   gpio_out            : serial read bit, qualified by gpio_out_valid
//   busy                : high whenever the controller is not IDLE
//   frame_error         : pulses on an aborted or rejected frame
// Build option GPIO_PACKET_PARITY_EN: each frame carries one trailing even
// parity bit over the packet; a mismatch rejects the frame.
// All outputs come straight from flops.
module gpio_packet_shifter
   import openram_gpio_pkg::*;
#(
   parameter int PACKET_WIDTH = PACKET_WIDTH_DEF,
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int READ_WAIT    = 4
) (
   input  logic                    gpio_clock,
   input  logic                    reset_n,
   input  logic                    gpio_in,
   input  logic                    gpio_load,
   input  logic [DATA_WIDTH-1:0]   read_data,
   output logic [PACKET_WIDTH-1:0] packet_out,
   output logic                    packet_valid,
   output logic                    read_capture,
   output logic                    gpio_out,
   output logic                    gpio_out_valid,
   output logic                    busy,
   output logic                    frame_error
);

   localparam int CNT_W  = cnt_width(PACKET_WIDTH, DATA_WIDTH);
   localparam int WAIT_W = 4;
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  OUT_INIT  = CNT_W'(DATA_WIDTH - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(READ_WAIT - 1);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
   logic                    load_q;
   logic                    load_rise;

   logic [PACKET_WIDTH-1:0] in_q;
   logic                    in_shift;
   logic                    out_load, out_shift;
   logic                    unused_in_msb;
   logic [DATA_WIDTH-1:0]   unused_out_q;

   logic                    last_ok;
   logic [PACKET_WIDTH-1:0] packet_next;
   logic                    packet_valid_d, read_capture_d, gpio_out_valid_d;
   logic                    busy_d, frame_error_d;

   assign load_rise = gpio_load & ~load_q;

`ifdef GPIO_PACKET_PARITY_EN
   // The first bit is taken in IDLE, so SHIFT_IN counts PACKET_WIDTH-1 down
   // to 0: the packet is complete in in_q and the cnt==0 bit is parity.
   localparam logic [CNT_W-1:0] IN_INIT = CNT_W'(PACKET_WIDTH - 1);
   assign last_ok     = ((^in_q) == gpio_in);
   assign packet_next = in_q;
`else
   // Last packet bit is still on gpio_in when the packet is published, so it
   // is appended here instead of waiting a cycle for the shift.
   localparam logic [CNT_W-1:0] IN_INIT = CNT_W'(PACKET_WIDTH - 2);
   logic unused_in_top;
   assign unused_in_top = in_q[PACKET_WIDTH-1];
   assign last_ok       = 1'b1;
   assign packet_next   = {in_q[PACKET_WIDTH-2:0], gpio_in};
`endif

   assign in_shift  = ((state_q == IDLE) && load_rise) ||
                      ((state_q == SHIFT_IN) && gpio_load);
   assign out_load  = (state_q == WAIT_READ) && (wait_cnt_q == '0);
   assign out_shift = (state_q == SHIFT_OUT);

   gpio_shift_reg #(.WIDTH(PACKET_WIDTH)) u_in_sr (
      .clk       (gpio_clock),
      .rst_n     (reset_n),
      .load      (1'b0),
      .load_data ('0),
      .shift_en  (in_shift),
      .serial_in (gpio_in),
      .data_q    (in_q),
      .msb_out   (unused_in_msb)
   );

   // Zero is shifted in behind the read word, so the register is clear again
   // once the last bit has gone and gpio_out idles low.
   gpio_shift_reg #(.WIDTH(DATA_WIDTH)) u_out_sr (
      .clk       (gpio_clock),
      .rst_n     (reset_n),
      .load      (out_load),
      .load_data (read_data),
      .shift_en  (out_shift),
      .serial_in (1'b0),
      .data_q    (unused_out_q),
      .msb_out   (gpio_out)
   );

   // State and counter register
   always_ff @(posedge gpio_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next state
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         IDLE: begin
            if (load_rise) begin
               state_d   = SHIFT_IN;
               bit_cnt_d = IN_INIT;
            end
         end
         SHIFT_IN: begin
            if (!gpio_load)
               state_d = IDLE;
            else if (bit_cnt_q == '0)
               state_d = last_ok ? LAUNCH : IDLE;
            else
               bit_cnt_d = bit_cnt_q - CNT_ONE;
         end
         LAUNCH: begin
            state_d    = WAIT_READ;
            wait_cnt_d = WAIT_INIT;
         end
         WAIT_READ: begin
            if (wait_cnt_q == '0) begin
               state_d   = SHIFT_OUT;
               bit_cnt_d = OUT_INIT;
            end else begin
               wait_cnt_d = wait_cnt_q - WAIT_ONE;
            end
         end
         SHIFT_OUT: begin
            if (bit_cnt_q == '0)
               state_d = IDLE;
            else
               bit_cnt_d = bit_cnt_q - CNT_ONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output next-values, computed from the upcoming state so the registered
   // strobes line up with the state they describe.
   always_comb begin
      packet_valid_d   = (state_q == SHIFT_IN) && gpio_load &&
                         (bit_cnt_q == '0) && last_ok;
      read_capture_d   = (state_d == WAIT_READ) && (wait_cnt_d == '0);
      gpio_out_valid_d = (state_d == SHIFT_OUT);
      busy_d           = (state_d != IDLE);
      frame_error_d    = ((state_q == SHIFT_IN) && !gpio_load) ||
                         ((state_q == SHIFT_IN) && gpio_load &&
                          (bit_cnt_q == '0) && !last_ok) ||
                         (load_rise && (state_q != IDLE) && (state_q != SHIFT_IN));
   end

   always_ff @(posedge gpio_clock or negedge reset_n) begin
      if (!reset_n) begin
         packet_out     <= '0;
         packet_valid   <= 1'b0;
         read_capture   <= 1'b0;
         gpio_out_valid <= 1'b0;
         busy           <= 1'b0;
         frame_error    <= 1'b0;
         load_q         <= 1'b0;
      end else begin
         if (packet_valid_d)
            packet_out <= packet_next;
         packet_valid   <= packet_valid_d;
         read_capture   <= read_capture_d;
         gpio_out_valid <= gpio_out_valid_d;
         busy           <= busy_d;
         frame_error    <= frame_error_d;
         load_q         <= gpio_load;
      end
   end

endmodule

// File: tb/tb_gpio_packet_shifter.sv
// Scoreboard bench for gpio_packet_shifter: stimulus pushes expected packets,
// capture cycles, serial bits and frame errors; a negedge monitor pops and
// compares them as the design presents each output strobe.
module tb_gpio_packet_shifter;
   import openram_gpio_pkg::*;

   localparam int PW = 86;
   localparam int DW = 64;
   localparam int RW = 4;
`ifdef GPIO_PACKET_PARITY_EN
   localparam int XB = 1;
`else
   localparam int XB = 0;
`endif

   logic          gpio_clock = 1'b0;
   logic          reset_n    = 1'b0;
   logic          gpio_in    = 1'b0;
   logic          gpio_load  = 1'b0;
   logic [DW-1:0] read_data  = '0;
   logic [PW-1:0] packet_out;
   logic          packet_valid, read_capture, gpio_out, gpio_out_valid;
   logic          busy, frame_error;

   gpio_packet_shifter #(.PACKET_WIDTH(PW), .DATA_WIDTH(DW), .READ_WAIT(RW)) dut (
      .gpio_clock     (gpio_clock),
      .reset_n        (reset_n),
      .gpio_in        (gpio_in),
      .gpio_load      (gpio_load),
      .read_data      (read_data),
      .packet_out     (packet_out),
      .packet_valid   (packet_valid),
      .read_capture   (read_capture),
      .gpio_out       (gpio_out),
      .gpio_out_valid (gpio_out_valid),
      .busy           (busy),
      .frame_error    (frame_error)
   );

   always #5 gpio_clock = ~gpio_clock;

   int cyc = 0;
   always @(posedge gpio_clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct { logic [PW-1:0] data; int cyc; } pkt_exp_t;
   typedef struct { logic b; int cyc; } bit_exp_t;
   pkt_exp_t pkt_q[$];
   bit_exp_t bit_q[$];
   int       cap_q[$];
   int       err_q[$];

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " packet_out"},     128'(packet_out),     128'(0));
      check({tag, " packet_valid"},   128'(packet_valid),   128'(0));
      check({tag, " read_capture"},   128'(read_capture),   128'(0));
      check({tag, " gpio_out"},       128'(gpio_out),       128'(0));
      check({tag, " gpio_out_valid"}, 128'(gpio_out_valid), 128'(0));
      check({tag, " busy"},           128'(busy),           128'(0));
      check({tag, " frame_error"},    128'(frame_error),    128'(0));
   endtask

   task automatic step();
      @(posedge gpio_clock);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step();
   endtask

   // Scoreboard entries for one complete frame starting at cycle t0.
   task automatic expect_frame(input logic [PW-1:0] pkt, input logic [DW-1:0] rd, input int t0);
      pkt_exp_t pe;
      bit_exp_t be;
      pe.data = pkt;
      pe.cyc  = t0 + PW + XB;
      pkt_q.push_back(pe);
      cap_q.push_back(t0 + PW + XB + RW);
      for (int i = 0; i < DW; i++) begin
         be.b   = rd[DW-1-i];
         be.cyc = t0 + PW + XB + RW + 1 + i;
         bit_q.push_back(be);
      end
   endtask

   // Drive nbits of a frame MSB first; bits past the packet are parity.
   task automatic send_frame(input logic [PW-1:0] pkt, input int nbits, input logic flip_par);
      for (int i = 0; i < nbits; i++) begin
         gpio_load = 1'b1;
         if (i < PW) gpio_in = pkt[PW-1-i];
         else        gpio_in = (^pkt) ^ flip_par;
         step();
      end
      gpio_load = 1'b0;
      gpio_in   = 1'b0;
   endtask

   // Monitor
   initial begin
      pkt_exp_t pe;
      bit_exp_t be;
      int       ce;
      forever begin
         @(negedge gpio_clock);
         if (reset_n) begin
            if (packet_valid) begin
               if (pkt_q.size() == 0) check("packet_valid unexpected", 128'(packet_valid), 128'(0));
               else begin
                  pe = pkt_q.pop_front();
                  check("packet_out", 128'(packet_out), 128'(pe.data));
                  check("packet cs", 128'(packet_out[CS_MSB:CS_LSB]), 128'(pe.data[CS_MSB:CS_LSB]));
                  check("packet_valid cycle", 128'(cyc), 128'(pe.cyc));
               end
            end
            if (read_capture) begin
               if (cap_q.size() == 0) check("read_capture unexpected", 128'(read_capture), 128'(0));
               else begin
                  ce = cap_q.pop_front();
                  check("read_capture cycle", 128'(cyc), 128'(ce));
               end
            end
            if (gpio_out_valid) begin
               if (bit_q.size() == 0) check("gpio_out_valid unexpected", 128'(gpio_out_valid), 128'(0));
               else begin
                  be = bit_q.pop_front();
                  check("gpio_out bit", 128'(gpio_out), 128'(be.b));
                  check("gpio_out cycle", 128'(cyc), 128'(be.cyc));
               end
            end
            if (frame_error) begin
               if (err_q.size() == 0) check("frame_error unexpected", 128'(frame_error), 128'(0));
               else begin
                  ce = err_q.pop_front();
                  check("frame_error cycle", 128'(cyc), 128'(ce));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: no finish by cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   // Stimulus
   initial begin
      logic [PW-1:0] pa, pb, pc, pd, pe;
      logic [DW-1:0] rd;
      int t;
      pa = {43{2'b10}};
      pb = {3'b111, 19'h0_0FFF, 64'hAAAA_5555_AAAA_5555};
      pc = {3'b011, 19'h5_A5A5, 64'hFEDC_BA98_7654_3210};
      pd = {3'b001, 19'h1_1111, 64'h1111_2222_3333_4444};
      pe = {3'b110, 19'h7_1234, 64'h0F0F_1234_5678_9ABC};

      #12;
      check_all_zero("reset");
      step();
      reset_n = 1'b1;
      step(); step();

      // Alternating packet, DEADBEEF readback
      rd = 64'hDEAD_BEEF_0123_4567;
      read_data = rd;
      t = cyc;
      expect_frame(pa, rd, t);
      send_frame(pa, PW + XB, 1'b0);
      wait_until(t + 100);
      check("busy mid frame", 128'(busy), 128'(1));
      wait_until(t + PW + XB + RW + DW + 1);
      check("busy after readback", 128'(busy), 128'(0));
      check("gpio_out_valid after readback", 128'(gpio_out_valid), 128'(0));

      // Frame dropped after 40 bits
      t = cyc;
      err_q.push_back(t + 41);
      send_frame(pb, 40, 1'b0);
      repeat (5) step();
      check("packet_out held after abort", 128'(packet_out), 128'(pa));
      check("busy after abort", 128'(busy), 128'(0));

      // Second frame with a fresh gpio_load edge during SHIFT_OUT
      rd = 64'h0123_4567_89AB_CDEF;
      read_data = rd;
      t = cyc;
      expect_frame(pc, rd, t);
      send_frame(pc, PW + XB, 1'b0);
      wait_until(t + PW + XB + RW + 10);
      gpio_load = 1'b1;
      err_q.push_back(cyc + 1);
      step(); step();
      gpio_load = 1'b0;
      wait_until(t + PW + XB + RW + DW + 1);
      check("busy after readback 2", 128'(busy), 128'(0));
      check("packet_out after readback 2", 128'(packet_out), 128'(pc));

      // Reset at bit 50
      for (int i = 0; i < 50; i++) begin
         gpio_load = 1'b1;
         gpio_in   = pd[PW-1-i];
         step();
      end
      reset_n = 1'b0;
      #1;
      check_all_zero("mid-frame reset");
      gpio_load = 1'b0;
      gpio_in   = 1'b0;
      step(); step();
      reset_n = 1'b1;
      step(); step();

      // Full frame after reset, MSB/LSB-only read word
      rd = 64'h8000_0000_0000_0001;
      read_data = rd;
      t = cyc;
      expect_frame(pe, rd, t);
      send_frame(pe, PW + XB, 1'b0);
      wait_until(t + PW + XB + RW + DW + 1);
      check("busy after readback 3", 128'(busy), 128'(0));

`ifdef GPIO_PACKET_PARITY_EN
      // Flipped parity bit: rejected, no packet, no readback
      t = cyc;
      err_q.push_back(t + PW + 1);
      send_frame(pb, PW + 1, 1'b1);
      repeat (RW + 8) step();
      check("packet_out held after parity error", 128'(packet_out), 128'(pe));
      check("busy after parity error", 128'(busy), 128'(0));
`endif

      repeat (5) step();
      check("packets drained", 128'(pkt_q.size()), 128'(0));
      check("captures drained", 128'(cap_q.size()), 128'(0));
      check("bits drained", 128'(bit_q.size()), 128'(0));
      check("errors drained", 128'(err_q.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gpio_packet_shifter.md
# gpio_packet_shifter

Serial front/back end for the OpenRAM test chip's GPIO path. Deserialises one 86-bit command packet (3-bit chip select + 83-bit SRAM connection word) from a single GPIO pin and presents it in parallel with a one-cycle valid strobe. After a fixed wait it captures the 64-bit SRAM read word and serialises it back out on a GPIO pin. It sits directly upstream of the SRAM test controller's packet input and downstream of its read-data output.

## Interface
- PACKET_WIDTH, 86, bits per command packet; bits [85:83] are chip select, [82:0] are the connection word
- DATA_WIDTH, 64, bits of read data returned per frame
- READ_WAIT, 4, cycles from packet_valid to read-data capture; legal range 1..15
- gpio_clock  in  1  sole clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- gpio_in  in  1  serial command data, MSB first
- gpio_load  in  1  frame enable; its rising edge starts a frame
- read_data  in  DATA_WIDTH  parallel read word from the SRAM test controller
- packet_out  out  PACKET_WIDTH  last complete packet, held until the next one completes
- packet_valid  out  1  one-cycle pulse when packet_out updates
- read_capture  out  1  one-cycle pulse on the cycle read_data is sampled
- gpio_out  out  1  serial read data, MSB first
- gpio_out_valid  out  1  high while gpio_out carries a read bit
- busy  out  1  high in every state except IDLE
- frame_error  out  1  one-cycle pulse on an aborted or rejected frame

## Operation
- States: IDLE, SHIFT_IN, LAUNCH, WAIT_READ, SHIFT_OUT.
- IDLE:
  - A registered copy of gpio_load provides rising-edge detection.
  - On the cycle where gpio_load = 1 and its previous value = 0, sample gpio_in as bit PACKET_WIDTH-1, load bit_cnt = PACKET_WIDTH-2 and enter SHIFT_IN.
- SHIFT_IN:
  - Sample gpio_in each cycle into the shift register (shift left) and decrement bit_cnt.
  - After the last bit (bit_cnt = 0 consumed), enter LAUNCH.
  - If gpio_load = 0 before the last bit: discard partial data, pulse frame_error, return to IDLE. packet_out is unchanged.
- LAUNCH: packet_out <= shift register, packet_valid = 1, load wait_cnt = READ_WAIT-1, enter WAIT_READ.
- WAIT_READ:
  - Decrement wait_cnt.
  - When it reaches 0: capture read_data into the output shift register, pulse read_capture, load bit_cnt = DATA_WIDTH-1, enter SHIFT_OUT.
- SHIFT_OUT:
  - gpio_out = output register MSB, gpio_out_valid = 1, shift left each cycle.
  - After DATA_WIDTH bits, return to IDLE.
- gpio_load held high beyond the packet end is ignored; a new frame requires a fresh rising edge.
- A rising edge of gpio_load while busy and not in SHIFT_IN is dropped and pulses frame_error.
- Counters are sized with clog2 of the larger width; they never wrap.

## Timing
- Reset values:
  - State IDLE.
  - packet_out = 0, packet_valid = 0, read_capture = 0, gpio_out = 0, gpio_out_valid = 0, busy = 0, frame_error = 0.
  - Registered gpio_load = 0.
- Edge at cycle T: bits are sampled T..T+85, packet_valid is high at T+86, read_capture at T+86+READ_WAIT, and gpio_out_valid spans the 64 cycles starting the cycle after read_capture.
- Frame-to-frame minimum: PACKET_WIDTH + READ_WAIT + DATA_WIDTH + 1 cycles.
- Reset asserted mid-frame:
  - Immediately clears all state and outputs, including packet_out.
  - No packet_valid is generated for the interrupted frame.
- All outputs are registered; no combinational path from any input to any output.

## Configuration
- GPIO_PACKET_PARITY_EN defined:
  - Each frame carries one extra trailing bit (even parity over the 86 packet bits), so SHIFT_IN lasts PACKET_WIDTH+1 cycles.
  - On mismatch: no LAUNCH, packet_out is held, frame_error pulses, and the state returns to IDLE with no readback.
- Undefined: no parity bit, no parity logic; behaviour is as described above.

## Structure
- Shared package openram_gpio_pkg holds:
  - the state enum;
  - the PACKET_WIDTH / DATA_WIDTH defaults;
  - the CS_MSB = 85 / CS_LSB = 83 field constants.
- One sub-module, gpio_shift_reg: a parameterised parallel-load/serial shift register with serial in, MSB out and shift enable. It is instantiated twice, once for packet input and once for read-data output.

## Test plan
- gpio_in = 86-bit pattern 0x2A_AAAA…(alternating), gpio_load held 86 cycles -> packet_out equals the pattern, packet_valid high exactly 1 cycle at T+86.
- read_data = 0xDEAD_BEEF_0123_4567 stable -> read_capture at T+90 (READ_WAIT = 4); gpio_out emits 1,1,0,1,1,1,1,0,… for 64 cycles with gpio_out_valid high; busy drops after.
- gpio_load dropped after 40 bits -> frame_error 1 pulse, packet_out keeps its previous value, no packet_valid, back to IDLE.
- New gpio_load rising edge during SHIFT_OUT -> frame_error pulse, serialisation uninterrupted, no new packet.
- reset_n low at bit 50 -> all outputs 0 immediately; next full frame after release decodes correctly.
- With GPIO_PACKET_PARITY_EN: good parity -> packet_valid; flipped parity bit -> frame_error, no packet_valid, gpio_out_valid never asserted.
